// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_pkg
// Description : Shared UART constants: default clock/baud values and the
//               transmit/receive FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_serializer_pkg;

    localparam int unsigned c_DEFAULT_CLK_FREQ = 50_000_000;
    localparam int unsigned c_DEFAULT_BAUD     = 115_200;

    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_START = 2'b01;
    localparam logic [1:0] c_ST_DATA  = 2'b10;
    localparam logic [1:0] c_ST_STOP  = 2'b11;

    typedef logic [7:0] tx_byte_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer_if
// Description : Byte request handshake and serial line of the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_serializer_if;
    import uart_tx_serializer_pkg::*;

    logic     TxD_start;
    tx_byte_t TxD_data;
    logic     TxD;
    logic     TxD_busy;

    modport master (output TxD_start, output TxD_data, input TxD, input TxD_busy);
    modport slave  (input TxD_start, input TxD_data, output TxD, output TxD_busy);

endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter; tick pulses on the last cycle of each bit.
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    output logic      tick
);

    localparam int              c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Suppressed while cleared so an idle line never produces a stray advance.
    assign tick = (r_count == c_LAST) && !clear;

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : 8N1 UART transmitter, LSB first, registered TxD/TxD_busy.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLK_FREQ     = c_DEFAULT_CLK_FREQ,
    parameter int BAUD         = c_DEFAULT_BAUD,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_tx_serializer_if.slave  tx
);

    logic [1:0] r_state;
    tx_byte_t   r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_txd;
    logic       r_busy;
    logic       w_tick;
    logic       w_clear;

    // Holding the counter at zero while idle makes the start bit exactly one period.
    assign w_clear = (r_state == c_ST_IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                    if (tx.TxD_start) begin
                        r_shift   <= tx.TxD_data;
                        r_bit_cnt <= '0;
                        r_txd     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        r_txd   <= r_shift[0];
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            // TxD takes the bit that becomes bit 0 after this shift.
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                c_ST_STOP: begin
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tx.TxD      = r_txd;
    assign tx.TxD_busy = r_busy;

endmodule
`default_nettype wire

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter CLK_FREQ, default 50000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: serial bit rate in bit/s.
REQ-003 Parameter CLKS_PER_BIT, default CLK_FREQ/BAUD (integer division, 434 at defaults): clock cycles per serial bit; shall be >= 2.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 TxD_start  input  1  request to send TxD_data; sampled only when idle.
REQ-007 TxD_data  input  8  byte to transmit; captured in the cycle TxD_start is accepted.
REQ-008 TxD  output  1  serial line, idle high, 8N1 framing, LSB first.
REQ-009 TxD_busy  output  1  high while a frame is in progress; upstream control waits for low before the next byte.

Function
REQ-010 The FSM shall have states IDLE, START, DATA, STOP.
REQ-011 In IDLE: TxD=1, TxD_busy=0; on a rising edge with TxD_start=1, the block shall latch TxD_data into an 8-bit shift register, clear the bit counter and baud counter, and enter START.
REQ-012 Acceptance edge: TxD shall be 0 and TxD_busy 1 immediately after the accepting edge (registered outputs, zero extra latency).
REQ-013 START shall hold TxD=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-014 DATA shall drive shift-register bit 0 for CLKS_PER_BIT cycles per bit, shift right after each bit, and after the 8th bit (bit index 7) enter STOP.
REQ-015 STOP shall hold TxD=1 for exactly CLKS_PER_BIT cycles, then return to IDLE with TxD_busy=0.
REQ-016 TxD_busy shall be high for exactly 10*CLKS_PER_BIT consecutive cycles per frame.
REQ-017 TxD_start while TxD_busy=1 shall be ignored; no queuing, no frame corruption.
REQ-018 Back-to-back: TxD_start high in the first cycle TxD_busy is low shall be accepted at that edge; the gap between stop bit end and next start bit shall be exactly one cycle.
REQ-019 TxD_data changes after acceptance shall not affect the frame in progress.
REQ-020 Baud counter shall count 0..CLKS_PER_BIT-1 and wrap to 0 at each bit boundary; it is held at 0 in IDLE.
REQ-021 Bit counter shall be 3 bits, range 0..7, and shall not wrap within a frame.
REQ-022 Unreachable state encodings shall recover to IDLE on the next edge.

Reset
REQ-023 While rst=1 at a rising edge: state=IDLE, TxD=1, TxD_busy=0, and shift register, bit counter and baud counter all 0.
REQ-024 Reset asserted mid-frame shall abort the frame; TxD shall be 1 and TxD_busy 0 after that edge, with no partial bit continued.
REQ-025 rst shall take priority over TxD_start in the same cycle.

Structure
REQ-026 State encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the default CLK_FREQ/BAUD values shall live in a shared include file used by the UART transmit and receive blocks.
REQ-027 Baud timing shall be a sub-module baud_tick_gen (clk, rst, clear, tick) that pulses tick on the last cycle of each bit period; the serializer FSM advances only on tick.
REQ-028 Outputs TxD and TxD_busy shall be driven directly from flops, with no combinational path from any input.

Verification
REQ-029 Bench parameters: CLK_FREQ=1600, BAUD=100, so CLKS_PER_BIT=16.
REQ-030 Send 0xA5 -> TxD bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles; TxD_busy high for 160 cycles.
REQ-031 Send 0x34, then pulse TxD_start with 0x12 at the first busy-low cycle -> two complete frames with a 1-cycle idle gap; decoded bytes 0x34 then 0x12.
REQ-032 Pulse TxD_start with 0xFF at cycle 50 of a 0x00 frame -> the 0x00 frame completes unchanged and no second frame is sent.
REQ-033 Change TxD_data from 0x5A to 0xC3 one cycle after acceptance -> the line carries 0x5A.
REQ-034 Assert rst for 1 cycle at cycle 70 of a frame -> TxD=1 and TxD_busy=0 at the next edge; a new start afterwards sends a clean frame.
